// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and default sizes for the counter sequencing controller.
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int unsigned DEF_WIDTH  = 2;
  localparam int unsigned DEF_PCNT_W = 8;

endpackage

// File: rtl/counter_seq_ctrl_counter.sv
// WIDTH-bit up/down counter datapath; load takes priority over enable.
module sync_updown_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Interval-timer sequencer: start/stop/hold control around the up/down counter,
// with terminal-count pulse, one-shot completion and saturating period count.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              up_dn,
  input  logic              periodic,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              tc_pulse,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lim_q, lim_d;
  logic                up_q, up_d;
  logic                per_q, per_d;
  logic                tc_q, tc_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [PCNT_W-1:0]   periods_q, periods_d;

  logic                cnt_load;
  logic                cnt_en;
  logic [WIDTH-1:0]    cnt_val;
  logic [WIDTH-1:0]    term;
  logic                at_term;

  sync_updown_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .up_dn    (up_q),
    .count    (count)
  );

  assign term    = up_q ? lim_q : '0;
  assign at_term = (count == term);

  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    up_d      = up_q;
    per_d     = per_q;
    tc_d      = 1'b0;
    periods_d = periods_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;

    if (stop) begin
      state_d   = ST_IDLE;
      periods_d = '0;
      cnt_load  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            lim_d     = limit;
            up_d      = up_dn;
            per_d     = periodic;
            periods_d = '0;
            cnt_load  = 1'b1;
            cnt_val   = up_dn ? '0 : limit;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          // Terminal detection wins over hold so no terminal event is lost.
          if (at_term) begin
            tc_d = 1'b1;
            if (periods_q != '1) begin
              periods_d = periods_q + 1'b1;
            end
            if (per_q) begin
              cnt_load = 1'b1;
              cnt_val  = up_q ? '0 : lim_q;
            end else begin
              state_d = ST_DONE;
            end
          end else if (hold) begin
            state_d = ST_PAUSE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!hold) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lim_q     <= '0;
      up_q      <= 1'b0;
      per_q     <= 1'b0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      lim_q     <= lim_d;
      up_q      <= up_d;
      per_q     <= per_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      periods_q <= periods_d;
    end
  end

  assign tc_pulse = tc_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign periods  = periods_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomized and directed checks of counter_seq_ctrl against a behavioural timer model.
module tb_counter_seq_ctrl;

  localparam int unsigned W    = 2;
  localparam int unsigned PW   = 2;
  localparam int unsigned PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic          up_dn = 1'b0, periodic = 1'b0;
  logic [W-1:0]  limit = '0;
  logic [W-1:0]  count;
  logic          busy, tc_pulse, done;
  logic [PW-1:0] periods;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model of the timer.
  bit m_running, m_paused, m_done, m_up, m_per, m_tc;
  int m_count, m_lim, m_periods;

  counter_seq_ctrl #(
    .WIDTH  (W),
    .PCNT_W (PW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .up_dn    (up_dn),
    .periodic (periodic),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done),
    .periods  (periods)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_paused = 0; m_done = 0; m_up = 0; m_per = 0; m_tc = 0;
    m_count = 0; m_lim = 0; m_periods = 0;
  endtask

  task automatic model_step();
    int t;
    m_tc = 0;
    if (stop) begin
      m_running = 0; m_paused = 0; m_done = 0;
      m_count = 0; m_periods = 0;
    end else if (start && !(m_running || m_paused)) begin
      m_lim = int'(limit); m_up = up_dn; m_per = periodic;
      m_count = m_up ? 0 : m_lim;
      m_running = 1; m_done = 0; m_periods = 0;
    end else if (m_running) begin
      t = m_up ? m_lim : 0;
      if (m_count == t) begin
        m_tc = 1;
        m_periods = (m_periods < PMAX) ? m_periods + 1 : PMAX;
        if (m_per) m_count = m_up ? 0 : m_lim;
        else begin
          m_running = 0; m_done = 1;
        end
      end else if (hold) begin
        m_running = 0; m_paused = 1;
      end else begin
        m_count = m_up ? m_count + 1 : m_count - 1;
      end
    end else if (m_paused && !hold) begin
      m_paused = 0; m_running = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"},   count,    m_count);
    check({tag, ".busy"},    busy,     m_running || m_paused);
    check({tag, ".done"},    done,     m_done);
    check({tag, ".tc"},      tc_pulse, m_tc);
    check({tag, ".periods"}, periods,  m_periods);
  endtask

  task automatic cycle(input string tag, input logic st, input logic sp, input logic hd,
                       input logic ud, input logic pr, input int lm);
    start = st; stop = sp; hold = hd; up_dn = ud; periodic = pr; limit = W'(lm);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0);
  endtask

  int seq2 [4] = '{0, 1, 2, 3};
  int seq3 [7] = '{2, 1, 0, 2, 1, 0, 2};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-run with count=2: outputs clear without a clock edge.
    cycle("t1", 1, 0, 0, 1, 1, 3);
    idle_cycles("t1", 2);
    check("t1.pre_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("t1.async");
    @(negedge clk);
    rst_n = 1'b1;

    // Up, one-shot, limit=3.
    cycle("t2", 1, 0, 0, 1, 0, 3);
    check("t2.seq", count, seq2[0]);
    for (int i = 1; i < 4; i++) begin
      cycle("t2", 0, 0, 0, 0, 1, 0);
      check("t2.seq", count, seq2[i]);
    end
    cycle("t2.term", 0, 0, 0, 0, 0, 0);
    check("t2.done", done, 1);
    check("t2.tc", tc_pulse, 1);
    check("t2.periods", periods, 1);
    idle_cycles("t2.hold", 3);
    check("t2.holdcount", count, 3);

    // Down, periodic, limit=2.
    cycle("t3", 1, 0, 0, 0, 1, 2);
    check("t3.seq", count, seq3[0]);
    for (int i = 1; i < 7; i++) begin
      cycle("t3", 0, 0, 0, 1, 0, 1);
      check("t3.seq", count, seq3[i]);
      check("t3.busy", busy, 1);
    end
    check("t3.periods", periods, 2);
    cycle("t3.stop", 0, 1, 0, 0, 0, 0);

    // Hold for 3 cycles while count=1.
    cycle("t4", 1, 0, 0, 1, 1, 3);
    cycle("t4", 0, 0, 0, 1, 1, 3);
    for (int i = 0; i < 3; i++) begin
      cycle("t4.hold", 0, 0, 1, 1, 1, 3);
      check("t4.frozen", count, 1);
    end
    cycle("t4.release", 0, 0, 0, 1, 1, 3);
    cycle("t4.resume", 0, 0, 0, 1, 1, 3);
    check("t4.next", count, 2);

    // Start alone ignored in RUN; stop+start returns to IDLE.
    cycle("t5.ign", 1, 0, 0, 0, 0, 0);
    check("t5.ign_count", count, 3);
    cycle("t5.both", 1, 1, 0, 1, 1, 3);
    check("t5.both_count", count, 0);
    check("t5.both_busy", busy, 0);

    // limit=0 up periodic: tc every cycle, periods saturates.
    cycle("t6", 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cycle("t6", 0, 0, 0, 0, 0, 2);
      check("t6.tc", tc_pulse, 1);
      check("t6.count", count, 0);
    end
    check("t6.sat", periods, PMAX);
    cycle("t6.stop", 0, 1, 0, 0, 0, 0);

    // Randomized command traffic.
    for (int i = 0; i < 600; i++) begin
      cycle("rand",
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
